ecc_point_check: RTL and testbench

ECC_POINT_CHECK -- requirements
Module: ecc_point_check

---
 rtl/ecc_pkg.sv | 29 ++
 rtl/mont_mul.sv | 87 ++++++++
 rtl/ecc_point_check.sv | 179 +++++++++++++++++
 tb/tb_ecc_point_check.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and helpers for the ECC point-on-curve checker
package ecc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RANGE,
      ST_MUL,
      ST_ADD1,
      ST_ADD2,
      ST_CMP
   } state_e;

   // Order of the eight Montgomery products; also indexes the product registers
   typedef enum logic [2:0] {
      STEP_XM,
      STEP_YM,
      STEP_AM,
      STEP_BM,
      STEP_Y2,
      STEP_X2,
      STEP_X3,
      STEP_AX
   } mul_step_e;

   function automatic int mm_latency(input int len);
      return len + 2;
   endfunction

endpackage

// File: rtl/mont_mul.sv
// rtl/mont_mul.sv - radix-2 bit-serial Montgomery multiplier, result = u*v*2^-LEN mod p
module mont_mul
   import ecc_pkg::*;
#(
   parameter int LEN = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [LEN-1:0] u,
   input  logic [LEN-1:0] v,
   input  logic [LEN-1:0] p,
   output logic           done,
   output logic [LEN-1:0] result
);

   localparam int MM_LATENCY = mm_latency(LEN);
   localparam int CW         = $clog2(MM_LATENCY);

   logic           run_q, run_d, fin_q, fin_d, done_q, done_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [LEN:0]   acc_q, acc_d;
   logic [LEN-1:0] u_q, u_d, v_q, v_d, result_q, result_d;
   logic [LEN+1:0] sum1, sum2;
   logic [LEN:0]   red;

   // Accumulator stays below 2p, so LEN+1 bits hold it and LEN+2 hold the sum
   always_comb begin
      run_d    = run_q;
      fin_d    = fin_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      u_d      = u_q;
      v_d      = v_q;
      result_d = result_q;
      done_d   = 1'b0;
      sum1     = {1'b0, acc_q} + (u_q[0] ? {2'b00, v_q} : '0);
      sum2     = sum1 + (sum1[0] ? {2'b00, p} : '0);
      red      = acc_q - {1'b0, p};
      if (start) begin
         u_d   = u;
         v_d   = v;
         acc_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
         fin_d = 1'b0;
      end else if (run_q) begin
         acc_d = (LEN+1)'(sum2 >> 1);
         u_d   = u_q >> 1;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(LEN-1)) begin
            run_d = 1'b0;
            fin_d = 1'b1;
         end
      end else if (fin_q) begin
         fin_d    = 1'b0;
         done_d   = 1'b1;
         result_d = (acc_q >= {1'b0, p}) ? LEN'(red) : LEN'(acc_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         fin_q    <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         u_q      <= '0;
         v_q      <= '0;
         result_q <= '0;
      end else begin
         run_q    <= run_d;
         fin_q    <= fin_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         u_q      <= u_d;
         v_q      <= v_d;
         result_q <= result_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: rtl/ecc_point_check.sv
// rtl/ecc_point_check.sv - checks y^2 == x^3 + a*x + b (mod p) in the Montgomery domain
module ecc_point_check
   import ecc_pkg::*;
#(
   parameter int LEN = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enable,
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] b,
   input  logic [LEN-1:0] p,
   input  logic [LEN-1:0] r2_mod_p,
   input  logic [LEN-1:0] x,
   input  logic [LEN-1:0] y,
   output logic           on_curve,
   output logic           valid,
   output logic           done,
   output logic           busy
);

   state_e         state_q, state_d;
   mul_step_e      step_q, step_d;
   logic           busy_q, busy_d, valid_q, valid_d, on_curve_q, on_curve_d;
   logic           done_q, done_d, fail_q, fail_d;
   logic [LEN-1:0] a_q, a_d, b_q, b_d, p_q, p_d, r2_q, r2_d, x_q, x_d, y_q, y_d;
   logic [LEN-1:0] s_q, s_d, rhs_q, rhs_d;
   logic [LEN-1:0] prod_q [8];
   logic [LEN-1:0] prod_d [8];
   logic           mm_start, mm_done;
   logic [LEN-1:0] mm_u, mm_v, mm_result;

   function automatic logic [LEN-1:0] mod_add(input logic [LEN-1:0] m, input logic [LEN-1:0] n,
                                              input logic [LEN-1:0] md);
      logic [LEN:0] sum, dif;
      sum = {1'b0, m} + {1'b0, n};
      dif = sum - {1'b0, md};
      return (sum >= {1'b0, md}) ? LEN'(dif) : LEN'(sum);
   endfunction

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      busy_d     = busy_q;
      valid_d    = valid_q;
      on_curve_d = on_curve_q;
      done_d     = 1'b0;
      fail_d     = fail_q;
      a_d        = a_q;
      b_d        = b_q;
      p_d        = p_q;
      r2_d       = r2_q;
      x_d        = x_q;
      y_d        = y_q;
      s_d        = s_q;
      rhs_d      = rhs_q;
      prod_d     = prod_q;
      mm_start   = 1'b0;
      case (state_q)
         ST_IDLE: if (enable) begin
            a_d        = a;
            b_d        = b;
            p_d        = p;
            r2_d       = r2_mod_p;
            x_d        = x;
            y_d        = y;
            valid_d    = 1'b0;
            on_curve_d = 1'b0;
            busy_d     = 1'b1;
            step_d     = STEP_XM;
            state_d    = ST_RANGE;
         end
         ST_RANGE: begin
            fail_d = (x_q >= p_q) || (y_q >= p_q);
            if (fail_d) begin
               state_d = ST_CMP;
            end else begin
               mm_start = 1'b1;
               state_d  = ST_MUL;
            end
         end
         // Each finished product immediately launches the next one on the same edge
         ST_MUL: if (mm_done) begin
            prod_d[step_q] = mm_result;
            if (step_q == STEP_AX) begin
               state_d = ST_ADD1;
            end else begin
               step_d   = mul_step_e'(step_q + 3'd1);
               mm_start = 1'b1;
            end
         end
         ST_ADD1: begin
            s_d     = mod_add(prod_q[STEP_X3], prod_q[STEP_AX], p_q);
            state_d = ST_ADD2;
         end
         ST_ADD2: begin
            rhs_d   = mod_add(s_q, prod_q[STEP_BM], p_q);
            state_d = ST_CMP;
         end
         ST_CMP: begin
            on_curve_d = !fail_q && (prod_q[STEP_Y2] == rhs_q);
            valid_d    = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // x2 feeds the very next product, so operands come from the _d view
      mm_u = x_q;
      mm_v = r2_q;
      case (step_d)
         STEP_XM: begin mm_u = x_q;             mm_v = r2_q;             end
         STEP_YM: begin mm_u = y_q;             mm_v = r2_q;             end
         STEP_AM: begin mm_u = a_q;             mm_v = r2_q;             end
         STEP_BM: begin mm_u = b_q;             mm_v = r2_q;             end
         STEP_Y2: begin mm_u = prod_d[STEP_YM]; mm_v = prod_d[STEP_YM]; end
         STEP_X2: begin mm_u = prod_d[STEP_XM]; mm_v = prod_d[STEP_XM]; end
         STEP_X3: begin mm_u = prod_d[STEP_X2]; mm_v = prod_d[STEP_XM]; end
         default: begin mm_u = prod_d[STEP_AM]; mm_v = prod_d[STEP_XM]; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         step_q     <= STEP_XM;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         on_curve_q <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         p_q        <= '0;
         r2_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         s_q        <= '0;
         rhs_q      <= '0;
         for (int i = 0; i < 8; i++) prod_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         on_curve_q <= on_curve_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
         a_q        <= a_d;
         b_q        <= b_d;
         p_q        <= p_d;
         r2_q       <= r2_d;
         x_q        <= x_d;
         y_q        <= y_d;
         s_q        <= s_d;
         rhs_q      <= rhs_d;
         prod_q     <= prod_d;
      end
   end

   mont_mul #(.LEN(LEN)) u_mont_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mm_start),
      .u      (mm_u),
      .v      (mm_v),
      .p      (p_q),
      .done   (mm_done),
      .result (mm_result)
   );

   assign on_curve = on_curve_q;
   assign valid    = valid_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ecc_point_check.sv
// tb/tb_ecc_point_check.sv - directed P-256 point checks against a big-integer curve model
module tb_ecc_point_check;

   localparam int LEN = 256;
   localparam logic [LEN-1:0] P256 = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
   localparam logic [LEN-1:0] A256 = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffc;
   localparam logic [LEN-1:0] B256 = 256'h5ac635d8aa3a93e7b3ebbd55769886bc651d06b0cc53b0f63bce3c3e27d2604b;
   localparam logic [LEN-1:0] GX   = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
   localparam logic [LEN-1:0] GY   = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;
   localparam logic [LEN-1:0] GYF  = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f4;
   localparam logic [LEN-1:0] G2X  = 256'h7cf27b188d034f7e8a52380304b51ac3c08969e277f21b35a60b48fc47669978;
   localparam logic [LEN-1:0] G2Y  = 256'h07775510db8ed040293d9ac69f7430dbba7dade63ce982299e04b79d227873d1;
   localparam logic [LEN-1:0] G3X  = 256'h5ecbe4d1a6330a44c8f7ef951d4bf165e6c6b721efada985fb41661bc6e7fd6c;
   localparam logic [LEN-1:0] G3Y  = 256'h8734640c4998ff7e374b06ce1a64a2ecd82ab036384fb83d9a79b127a27d5032;
   localparam int FULL_LAT  = 8*LEN + 20;
   localparam int RANGE_LAT = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic [LEN-1:0] a = '0, b = '0, p = '0, r2_mod_p = '0, x = '0, y = '0;
   logic           on_curve, valid, done, busy;

   int   n_pass = 0;
   int   n_total = 0;
   logic exp_oc = 1'b0;
   bit   exp_live = 1'b0;

   always #5 clk = ~clk;

   ecc_point_check #(.LEN(LEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .a        (a),
      .b        (b),
      .p        (p),
      .r2_mod_p (r2_mod_p),
      .x        (x),
      .y        (y),
      .on_curve (on_curve),
      .valid    (valid),
      .done     (done),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Plain modular arithmetic on double-width integers
   function automatic logic model_oc(input logic [LEN-1:0] ca, input logic [LEN-1:0] cb,
                                     input logic [LEN-1:0] cp, input logic [LEN-1:0] px,
                                     input logic [LEN-1:0] py);
      logic [2*LEN-1:0] mp, mx, my, ma, mb, lhs, rhs;
      if (px >= cp || py >= cp) return 1'b0;
      mp  = {{LEN{1'b0}}, cp};
      mx  = {{LEN{1'b0}}, px};
      my  = {{LEN{1'b0}}, py};
      ma  = {{LEN{1'b0}}, ca};
      mb  = {{LEN{1'b0}}, cb};
      lhs = (my * my) % mp;
      rhs = (mx * mx) % mp;
      rhs = (rhs * mx) % mp;
      rhs = (rhs + ((ma * mx) % mp) + mb) % mp;
      return lhs == rhs;
   endfunction

   always @(negedge clk) begin
      if (exp_live && rst_n && valid) chk("cmp_on_curve", on_curve, exp_oc);
      if (rst_n && done) chk("cmp_done_flags", {valid, busy}, 2'b10);
   end

   task automatic run(input string name, input logic [LEN-1:0] ca, input logic [LEN-1:0] cb,
                      input logic [LEN-1:0] cx, input logic [LEN-1:0] cy,
                      input int exp_lat, input logic exp_lit, input bit pulse);
      int   lat;
      int   extra;
      logic got;
      @(negedge clk);
      a = ca; b = cb; x = cx; y = cy; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_oc = model_oc(ca, cb, p, cx, cy);
      chk({name, "_busy_at_capture"}, busy, 1);
      chk({name, "_valid_cleared"}, {valid, on_curve}, 0);
      a = '0; b = '1; x = p; y = '0; enable = pulse;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 3000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         enable = pulse && (lat == 500 || lat == FULL_LAT - 1);
         got = done;
      end
      enable = 1'b0;
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_on_curve"}, on_curve, exp_lit);
      chk({name, "_valid_idle"}, {valid, busy}, 2'b10);
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk({name, "_single_done"}, extra, 0);
      chk({name, "_hold"}, {valid, on_curve}, {1'b1, exp_lit});
   endtask

   initial begin
      logic [2*LEN:0] big, pw, rr;
      int             ndone;
      p   = P256;
      big = '0;
      big[2*LEN] = 1'b1;
      pw  = {{(LEN+1){1'b0}}, P256};
      rr  = big % pw;
      r2_mod_p = rr[LEN-1:0];

      #1;
      chk("reset_outputs", {on_curve, valid, done, busy}, 0);

      chk("model_G", model_oc(A256, B256, P256, GX, GY), 1);
      chk("model_G_flip", model_oc(A256, B256, P256, GX, GYF), 0);
      chk("model_2G", model_oc(A256, B256, P256, G2X, G2Y), 1);
      chk("model_zero_b0", model_oc(A256, '0, P256, '0, '0), 1);
      chk("model_zero_b", model_oc(A256, B256, P256, '0, '0), 0);
      chk("model_x_eq_p", model_oc(A256, B256, P256, P256, GY), 0);

      @(negedge clk);
      rst_n = 1'b1;
      exp_live = 1'b1;

      run("G", A256, B256, GX, GY, FULL_LAT, 1'b1, 1'b1);
      run("G_flip", A256, B256, GX, GYF, FULL_LAT, 1'b0, 1'b0);
      run("G2", A256, B256, G2X, G2Y, FULL_LAT, 1'b1, 1'b0);
      run("G3", A256, B256, G3X, G3Y, FULL_LAT, model_oc(A256, B256, P256, G3X, G3Y), 1'b0);
      run("x_eq_p", A256, B256, P256, GY, RANGE_LAT, 1'b0, 1'b1);
      run("y_eq_p", A256, B256, GX, P256, RANGE_LAT, 1'b0, 1'b0);
      run("zero_b0", A256, '0, '0, '0, FULL_LAT, 1'b1, 1'b0);

      @(negedge clk);
      a = A256; b = B256; x = GX; y = GY; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (998) @(posedge clk);
      #2;
      chk("busy_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_async_mid", {on_curve, valid, done, busy}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (2200) begin
         @(negedge clk);
         if (done || busy || valid) ndone++;
      end
      chk("no_activity_after_reset", ndone, 0);
      run("G_rerun", A256, B256, GX, GY, FULL_LAT, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
